// File: rtl/divider_sequencer.sv
// Sequencer for the restoring divider datapath.
// Accepts a request on start/ready, walks the datapath through WORD_LENGTH
// iteration cycles (init-select, step-enable, final-capture strobes) and
// presents the result on a result_valid/result_ready handshake. A zero divisor
// skips the iterations and is reported through div_by_zero.
module divider_sequencer #(
    parameter  int WORD_LENGTH = 16,
    localparam int CNT_WIDTH   = $clog2(WORD_LENGTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic                   ready,
    output logic                   load,
    output logic                   step_en,
    output logic                   capture_en,
    output logic [CNT_WIDTH-1:0]   iter_count,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WORD_LENGTH - 1);

    state_t state;
    state_t state_next;
    logic   last_iter;
    logic   divisor_zero;

    assign last_iter    = (iter_count == LAST_ITER);
    assign divisor_zero = (divisor == '0);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours; blocking here would make
    // the result depend on statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start and result_ready only matter in IDLE and DONE.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: state_next = S_ITER;
            S_ITER: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are pure decodes of registered state, so start never reaches them combinationally.
    always_comb begin
        ready        = 1'b0;
        load         = 1'b0;
        step_en      = 1'b0;
        capture_en   = 1'b0;
        result_valid = 1'b0;
        case (state)
            S_IDLE: ready = 1'b1;
            S_LOAD: begin
                load    = 1'b1;
                step_en = 1'b1;
            end
            S_ITER: begin
                step_en    = 1'b1;
                capture_en = last_iter;
            end
            S_DONE:  result_valid = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Iteration counter: cleared in IDLE, advances through LOAD/ITER, saturates at the last index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_count <= '0;
        end else begin
            case (state)
                S_IDLE: iter_count <= '0;
                S_LOAD, S_ITER: begin
                    if (!last_iter) begin
                        iter_count <= iter_count + 1'b1;
                    end
                end
                default: iter_count <= iter_count;
            endcase
        end
    end

    // Divide-by-zero flag: latched on acceptance, cleared when the result is consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_by_zero <= 1'b0;
        end else if (state == S_IDLE && start) begin
            div_by_zero <= divisor_zero;
        end else if (state == S_DONE && result_ready) begin
            div_by_zero <= 1'b0;
        end
    end

endmodule
